minmax_framer: RTL and testbench

Input sequencer for the MinMax datapath. Converts a gappy valid/start-of-frame sample stream into the `clear`/`enable`/`reset`/`in` control set the MinMax stage consumes. It opens a fresh min/max window on every frame start or after `FRAME_LEN` samples. During short gaps it re-presents the last sample, which leaves min/max unchanged, so windows survive stalls. It abandons the window after `TIMEOUT` idle cycles.

---
 rtl/minmax_framer.sv | 119 +++++++++++
 tb/tb_minmax_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_framer.sv
// Input sequencer for the MinMax stage: turns a gappy valid/sof sample
// stream into registered clear/enable/reset/data controls, bridging short
// stalls by repeating the last sample and closing the window on timeout.
module minmax_framer #(
  parameter int unsigned MSB       = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned TIMEOUT   = 4,
  parameter int unsigned CW        = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [MSB:0]  in_data,
  output logic          mm_clear,
  output logic          mm_enable,
  output logic          mm_reset,
  output logic [MSB:0]  mm_in,
  output logic          win_start,
  output logic [CW-1:0] win_count,
  output logic          busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] TIMEOUT_C   = CW'(TIMEOUT);

  logic [0:0]    state_q, state_d;
  logic [MSB:0]  held_q, held_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          mm_clear_q, mm_clear_d;
  logic          mm_enable_q, mm_enable_d;
  logic          mm_reset_q, mm_reset_d;
  logic [MSB:0]  mm_in_q, mm_in_d;

  // Next-state and next-output decode; clear overrides every other case.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    count_d     = count_q;
    gap_d       = gap_q;
    mm_clear_d  = 1'b0;
    mm_enable_d = 1'b0;
    mm_reset_d  = 1'b0;
    mm_in_d     = held_q;

    if (clear) begin
      mm_clear_d = 1'b1;
      mm_in_d    = '0;
      state_d    = S_IDLE;
      held_d     = '0;
      count_d    = '0;
      gap_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mm_enable_d = 1'b1;
            mm_reset_d  = 1'b1;
            mm_in_d     = in_data;
            held_d      = in_data;
            count_d     = CW'(1);
            gap_d       = '0;
            state_d     = S_RUN;
          end else begin
            count_d = '0;
          end
        end
        default: begin
          if (in_valid) begin
            mm_enable_d = 1'b1;
            mm_in_d     = in_data;
            held_d      = in_data;
            gap_d       = '0;
            // sof and a full window together still give a single restart
            if (in_sof || (count_q == FRAME_LEN_C)) begin
              mm_reset_d = 1'b1;
              count_d    = CW'(1);
            end else begin
              count_d = count_q + CW'(1);
            end
          end else if ((gap_q + CW'(1)) == TIMEOUT_C) begin
            count_d = '0;
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            // repeating held keeps min/max unchanged across the stall
            mm_enable_d = 1'b1;
            gap_d       = gap_q + CW'(1);
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    held_q      <= held_d;
    count_q     <= count_d;
    gap_q       <= gap_d;
    mm_clear_q  <= mm_clear_d;
    mm_enable_q <= mm_enable_d;
    mm_reset_q  <= mm_reset_d;
    mm_in_q     <= mm_in_d;
  end

  assign mm_clear  = mm_clear_q;
  assign mm_enable = mm_enable_q;
  assign mm_reset  = mm_reset_q;
  assign mm_in     = mm_in_q;
  assign win_start = mm_reset_q;
  assign win_count = count_q;
  assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_minmax_framer.sv
// Directed bench for minmax_framer with FRAME_LEN=4, TIMEOUT=3.
module tb_minmax_framer;

  localparam int unsigned MSB = 8;
  localparam int unsigned CW  = 8;

  logic          clock;
  logic          clear;
  logic          in_valid;
  logic          in_sof;
  logic [MSB:0]  in_data;
  logic          mm_clear;
  logic          mm_enable;
  logic          mm_reset;
  logic [MSB:0]  mm_in;
  logic          win_start;
  logic [CW-1:0] win_count;
  logic          busy;

  int checks;
  int failures;

  minmax_framer #(
    .MSB(MSB),
    .FRAME_LEN(4),
    .TIMEOUT(3),
    .CW(CW)
  ) dut (
    .clock(clock),
    .clear(clear),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_data(in_data),
    .mm_clear(mm_clear),
    .mm_enable(mm_enable),
    .mm_reset(mm_reset),
    .mm_in(mm_in),
    .win_start(win_start),
    .win_count(win_count),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one input cycle, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic c, input logic v, input logic s, input int d);
    clear    = c;
    in_valid = v;
    in_sof   = s;
    in_data  = (MSB+1)'(d);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 99);
    checks++;
    if ({mm_clear, mm_enable, mm_reset, win_start, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {mm_clear, mm_enable, mm_reset, win_start, busy});
    end
    checks++;
    if (mm_in !== 9'd0) begin
      failures++;
      $display("FAIL reset_mm_in got=%0d exp=0", mm_in);
    end
    checks++;
    if (win_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_win_count got=%0d exp=0", win_count);
    end
  endtask

  task automatic test_rollover();
    int d [5]      = '{10, 20, 30, 40, 50};
    logic e_rst [5] = '{1, 0, 0, 0, 1};
    int e_cnt [5]  = '{1, 2, 3, 4, 1};
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, d[i]);
      checks++;
      if (mm_in !== (MSB+1)'(d[i])) begin
        failures++;
        $display("FAIL rollover_mm_in[%0d] got=%0d exp=%0d", i, mm_in, d[i]);
      end
      checks++;
      if (mm_reset !== e_rst[i] || win_start !== e_rst[i]) begin
        failures++;
        $display("FAIL rollover_reset[%0d] got=%b/%b exp=%b", i, mm_reset, win_start, e_rst[i]);
      end
      checks++;
      if (win_count !== CW'(e_cnt[i])) begin
        failures++;
        $display("FAIL rollover_count[%0d] got=%0d exp=%0d", i, win_count, e_cnt[i]);
      end
      checks++;
      if (mm_enable !== 1'b1 || mm_clear !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rollover_en[%0d] got en=%b clr=%b busy=%b exp 1/0/1", i, mm_enable, mm_clear, busy);
      end
    end
  endtask

  task automatic test_short_gap();
    logic v [4]     = '{1, 0, 0, 1};
    int d [4]       = '{10, 0, 0, 30};
    int e_in [4]    = '{10, 10, 10, 30};
    logic e_rst [4] = '{1, 0, 0, 0};
    int e_cnt [4]   = '{1, 1, 1, 2};
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, v[i], 1'b0, d[i]);
      checks++;
      if (mm_in !== (MSB+1)'(e_in[i]) || mm_enable !== 1'b1) begin
        failures++;
        $display("FAIL gap_data[%0d] got in=%0d en=%b exp in=%0d en=1", i, mm_in, mm_enable, e_in[i]);
      end
      checks++;
      if (mm_reset !== e_rst[i] || win_count !== CW'(e_cnt[i])) begin
        failures++;
        $display("FAIL gap_ctl[%0d] got rst=%b cnt=%0d exp rst=%b cnt=%0d", i, mm_reset, win_count, e_rst[i], e_cnt[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic v [5]     = '{1, 0, 0, 0, 1};
    int d [5]       = '{7, 0, 0, 0, 9};
    logic e_en [5]  = '{1, 1, 1, 0, 1};
    int e_cnt [5]   = '{1, 1, 1, 0, 1};
    logic e_rst [5] = '{1, 0, 0, 0, 1};
    int e_in [5]    = '{7, 7, 7, 7, 9};
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, v[i], 1'b0, d[i]);
      checks++;
      if (mm_enable !== e_en[i] || busy !== e_en[i]) begin
        failures++;
        $display("FAIL timeout_en[%0d] got en=%b busy=%b exp=%b", i, mm_enable, busy, e_en[i]);
      end
      checks++;
      if (win_count !== CW'(e_cnt[i]) || mm_reset !== e_rst[i] || mm_in !== (MSB+1)'(e_in[i])) begin
        failures++;
        $display("FAIL timeout_ctl[%0d] got cnt=%0d rst=%b in=%0d exp cnt=%0d rst=%b in=%0d",
                 i, win_count, mm_reset, mm_in, e_cnt[i], e_rst[i], e_in[i]);
      end
    end
  endtask

  // sof on the first sample from IDLE is ignored beyond the normal restart.
  task automatic test_sof_mid();
    logic s [3]     = '{1, 0, 1};
    int d [3]       = '{5, 6, 8};
    logic e_rst [3] = '{1, 0, 1};
    int e_cnt [3]   = '{1, 2, 1};
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, s[i], d[i]);
      checks++;
      if (mm_reset !== e_rst[i] || win_count !== CW'(e_cnt[i]) || mm_in !== (MSB+1)'(d[i])) begin
        failures++;
        $display("FAIL sof[%0d] got rst=%b cnt=%0d in=%0d exp rst=%b cnt=%0d in=%0d",
                 i, mm_reset, win_count, mm_in, e_rst[i], e_cnt[i], d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e_rst [6] = '{1, 0, 0, 0, 1, 0};
    int e_cnt [6]   = '{1, 2, 3, 4, 1, 2};
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, (i == 4), 100 + i);
      checks++;
      if (mm_reset !== e_rst[i] || win_count !== CW'(e_cnt[i])) begin
        failures++;
        $display("FAIL coincident[%0d] got rst=%b cnt=%0d exp rst=%b cnt=%0d",
                 i, mm_reset, win_count, e_rst[i], e_cnt[i]);
      end
    end
  endtask

  task automatic test_clear_mid();
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1);
    cyc(1'b0, 1'b1, 1'b0, 2);
    cyc(1'b0, 1'b1, 1'b0, 3);
    checks++;
    if (win_count !== 8'd3) begin
      failures++;
      $display("FAIL clrmid_pre got cnt=%0d exp=3", win_count);
    end
    cyc(1'b1, 1'b1, 1'b0, 77);
    checks++;
    if (mm_clear !== 1'b1 || mm_enable !== 1'b0 || win_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clrmid_clear got clr=%b en=%b cnt=%0d busy=%b exp 1/0/0/0", mm_clear, mm_enable, win_count, busy);
    end
    cyc(1'b0, 1'b1, 1'b0, 42);
    checks++;
    if (mm_clear !== 1'b0 || mm_reset !== 1'b1 || mm_in !== 9'd42 || win_count !== 8'd1) begin
      failures++;
      $display("FAIL clrmid_after got clr=%b rst=%b in=%0d cnt=%0d exp 0/1/42/1", mm_clear, mm_reset, mm_in, win_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    test_reset();
    test_rollover();
    test_short_gap();
    test_timeout();
    test_sof_mid();
    test_back_to_back();
    test_clear_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
